// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between a truth-table sweeper and its controller.
// The slave side is the sweeper; the master side starts sweeps and supplies resp.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned ROWS = 1 << N_IN;

  logic            start;
  logic            resp;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic [ROWS-1:0] table_out;
  logic            table_valid;
  logic [N_IN:0]   ones_cnt;

  modport master (
    output start, resp,
    input  stim, busy, done, table_out, table_valid, ones_cnt
  );

  modport slave (
    input  start, resp,
    output stim, busy, done, table_out, table_valid, ones_cnt
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a combinational cell through every input combination, holding each for
// SETTLE cycles, and publishes the captured truth table plus its minterm count.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);
  localparam int unsigned ROWS  = 1 << N_IN;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned OC_W  = N_IN + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N_IN-1:0]  LAST_STIM  = N_IN'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  logic [1:0]       state, state_d;
  logic [N_IN-1:0]  stim, stim_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [ROWS-1:0]  shadow, shadow_d;
  logic [ROWS-1:0]  table_q, table_d;
  logic [OC_W-1:0]  ones_q, ones_d;
  logic             busy, busy_d;
  logic             done, done_d;
  logic             valid, valid_d;

  function automatic logic [OC_W-1:0] popcount(input logic [ROWS-1:0] v);
    logic [OC_W-1:0] n;
    n = '0;
    for (int i = 0; i < ROWS; i++) n = n + OC_W'(v[i]);
    return n;
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      stim    <= '0;
      cnt     <= '0;
      shadow  <= '0;
      table_q <= '0;
      ones_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state   <= state_d;
      stim    <= stim_d;
      cnt     <= cnt_d;
      shadow  <= shadow_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      busy    <= busy_d;
      done    <= done_d;
      valid   <= valid_d;
    end
  end

  // Next-state logic. Results are loaded on the edge entering DONE so that
  // table_out, ones_cnt and table_valid change in the same cycle done is high.
  always_comb begin
    state_d  = state;
    stim_d   = stim;
    cnt_d    = cnt;
    shadow_d = shadow;
    table_d  = table_q;
    ones_d   = ones_q;
    valid_d  = valid;
    case (state)
      S_IDLE: begin
        stim_d = '0;
        if (bus.start) begin
          state_d = S_WAIT;
          cnt_d   = CNT_RELOAD;
          valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          shadow_d[stim] = bus.resp;
          if (stim != LAST_STIM) begin
            stim_d = stim + N_IN'(1);
            cnt_d  = CNT_RELOAD;
          end else begin
            state_d = S_DONE;
            table_d = shadow_d;
            ones_d  = popcount(shadow_d);
            valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stim_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        stim_d  = '0;
      end
    endcase
    busy_d = (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
  end

  assign bus.stim        = stim;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.table_out   = table_q;
  assign bus.table_valid = valid;
  assign bus.ones_cnt    = ones_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=4 and SETTLE=1) sweep
// random cell functions; results are checked against cycle arithmetic and the target table.
module tb_truth_table_sweeper;
  localparam int unsigned N_IN = 3;
  localparam int unsigned ROWS = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(N_IN)) bus_a ();
  truth_table_sweeper_if #(.N_IN(N_IN)) bus_b ();

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic            sel;
  logic            start_drv;
  logic            glitch;
  logic [ROWS-1:0] func;
  logic [ROWS-1:0] last_tab [2];

  int total = 0;
  int bad   = 0;

  // The modelled cell: resp = func[stim], optionally inverted to emulate glitches.
  assign bus_a.start = !sel && start_drv;
  assign bus_b.start =  sel && start_drv;
  assign bus_a.resp  = glitch ? ~func[bus_a.stim] : func[bus_a.stim];
  assign bus_b.resp  = glitch ? ~func[bus_b.stim] : func[bus_b.stim];

  logic [N_IN-1:0] cur_stim;
  logic            cur_busy, cur_done, cur_valid;
  logic [ROWS-1:0] cur_table;
  logic [N_IN:0]   cur_ones;
  assign cur_stim  = sel ? bus_b.stim        : bus_a.stim;
  assign cur_busy  = sel ? bus_b.busy        : bus_a.busy;
  assign cur_done  = sel ? bus_b.done        : bus_a.done;
  assign cur_valid = sel ? bus_b.table_valid : bus_a.table_valid;
  assign cur_table = sel ? bus_b.table_out   : bus_a.table_out;
  assign cur_ones  = sel ? bus_b.ones_cnt    : bus_a.ones_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_ones(input logic [ROWS-1:0] t);
    int n = 0;
    for (int i = 0; i < ROWS; i++) if (t[i]) n++;
    return n;
  endfunction

  // One full sweep; cycle k is the k-th cycle after the edge that samples start.
  task automatic run_sweep(input bit s, input int settle, input logic [ROWS-1:0] f,
                           input bit glitch_en, input bit inject);
    int last;
    int row;
    int pos;
    sel  = s;
    func = f;
    last = 1 + int'(ROWS) * settle;
    @(negedge clk) start_drv = 1'b1;
    @(posedge clk);
    @(negedge clk) start_drv = 1'b0;
    for (int k = 1; k <= last + 3; k++) begin
      if (k > 1) @(negedge clk);
      row       = (k - 1) / settle;
      pos       = (k - 1) % settle;
      glitch    = glitch_en && (k < last) && (pos != settle - 1);
      start_drv = inject && (k == 5 || k == 20);
      if (k == 1) begin
        check("valid_drop", 32'(cur_valid), 32'd0);
        check("table_hold", 32'(cur_table), 32'(last_tab[s]));
      end
      if (k < last) begin
        check("stim", 32'(cur_stim), 32'(row));
        check("busy", 32'(cur_busy), 32'd1);
        check("done_early", 32'(cur_done), 32'd0);
      end else if (k == last) begin
        check("done", 32'(cur_done), 32'd1);
        check("busy_done", 32'(cur_busy), 32'd0);
        check("stim_last", 32'(cur_stim), 32'(ROWS - 1));
        check("table", 32'(cur_table), 32'(f));
        check("ones", 32'(cur_ones), 32'(ref_ones(f)));
        check("valid", 32'(cur_valid), 32'd1);
      end else begin
        check("done_after", 32'(cur_done), 32'd0);
        check("busy_idle", 32'(cur_busy), 32'd0);
        check("stim_idle", 32'(cur_stim), 32'd0);
        check("valid_keep", 32'(cur_valid), 32'd1);
      end
    end
    glitch    = 1'b0;
    start_drv = 1'b0;
    last_tab[s] = f;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
    check({tag, "_stim"}, 32'(bus_a.stim), 32'd0);
    check({tag, "_done"}, 32'(bus_a.done), 32'd0);
    check({tag, "_table"}, 32'(bus_a.table_out), 32'd0);
    check({tag, "_valid"}, 32'(bus_a.table_valid), 32'd0);
    check({tag, "_ones"}, 32'(bus_a.ones_cnt), 32'd0);
    check({tag, "_b_table"}, 32'(bus_b.table_out), 32'd0);
  endtask

  initial begin
    int dones;
    int first_done;
    int second_done;
    logic [ROWS-1:0] f;
    sel = 1'b0; start_drv = 1'b0; glitch = 1'b0; func = '0;
    last_tab[0] = '0; last_tab[1] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed functions: and of the upper two inputs, constants, stim[0].
    run_sweep(1'b0, 4, 8'hC0, 1'b0, 1'b0);
    run_sweep(1'b0, 4, 8'h00, 1'b0, 1'b0);
    run_sweep(1'b0, 4, 8'hFF, 1'b0, 1'b0);
    run_sweep(1'b1, 1, 8'hAA, 1'b0, 1'b0);
    // Starts during WAIT are ignored; the follow-up sweep shows the old table.
    run_sweep(1'b0, 4, 8'(($urandom)), 1'b0, 1'b1);
    run_sweep(1'b0, 4, 8'(($urandom)), 1'b0, 1'b0);
    // Early-row glitches must not reach the table.
    run_sweep(1'b0, 4, 8'h00, 1'b1, 1'b0);
    run_sweep(1'b0, 4, 8'(($urandom)), 1'b1, 1'b0);

    for (int n = 0; n < 8; n++) begin
      f = 8'($urandom);
      if ($urandom_range(0, 1) == 1) run_sweep(1'b1, 1, f, 1'b0, 1'b0);
      else                           run_sweep(1'b0, 4, f, $urandom_range(0, 1) == 1, 1'b0);
    end

    // Held start re-triggers from IDLE: done at cycles 33 and 67.
    sel = 1'b0; func = 8'h5A;
    dones = 0; first_done = -1; second_done = -1;
    @(negedge clk) start_drv = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (cur_done) begin
        dones++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
    end
    start_drv = 1'b0;
    check("held_done_cnt", 32'(dones), 32'd2);
    check("held_first", 32'(first_done), 32'd33);
    check("held_second", 32'(second_done), 32'd67);
    repeat (40) @(negedge clk);
    check("held_table", 32'(bus_a.table_out), 32'h5A);
    last_tab[0] = 8'h5A;

    // Asynchronous reset at cycle 10 aborts without publishing anything.
    sel = 1'b0; func = 8'hFF;
    @(negedge clk) start_drv = 1'b1;
    @(posedge clk);
    @(negedge clk) start_drv = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_state("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_a.done || bus_a.busy) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_valid", 32'(bus_a.table_valid), 32'd0);
    last_tab[0] = '0; last_tab[1] = '0;

    run_sweep(1'b0, 4, 8'h3C, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
